// File: rtl/video_ram_scanout_pkg.sv
// Shared constants, types and helpers for the video RAM scanout engine.
// Build option: define VIDEO_SCANOUT_DOUBLE_EN to show every stored pixel
// as a 2x2 block (128x64 visible from the 1024-word buffer).
package video_scanout_pkg;

  localparam int PIPE_LAT     = 3;   // counters -> pins, in clocks
  localparam int RAM_AW       = 10;
  localparam int RAM_DW       = 18;
  localparam int PIX_W        = 9;
  localparam int PIX_EVEN_LSB = 0;   // pixel with h-select 0
  localparam int PIX_ODD_LSB  = 9;   // pixel with h-select 1

`ifdef VIDEO_SCANOUT_DOUBLE_EN
  localparam int REP_SHIFT = 1;      // each stored pixel/row shown twice
`else
  localparam int REP_SHIFT = 0;      // 1:1 mapping
`endif

  localparam int DEF_H_ACTIVE = 64 << REP_SHIFT;
  localparam int DEF_V_ACTIVE = 32 << REP_SHIFT;

  typedef struct packed {
    logic [2:0] r;
    logic [2:0] g;
    logic [2:0] b;
  } rgb333_t;

  // Per-pixel side information that travels alongside the RAM access.
  typedef struct packed {
    logic valid;   // visible pixel
    logic hsync;   // active-high horizontal sync
    logic vsync;   // active-high vertical sync
    logic first;   // first visible pixel of the frame
    logic sel;     // 0: even pixel field, 1: odd pixel field
  } pipe_tag_t;

  function automatic rgb333_t pixel_slice(input logic [RAM_DW-1:0] word,
                                          input logic odd);
    rgb333_t pix;
    if (odd) pix = word[PIX_ODD_LSB +: PIX_W];
    else     pix = word[PIX_EVEN_LSB +: PIX_W];
    return pix;
  endfunction

endpackage

// File: rtl/video_ram_scanout_if.sv
// Port B of the 1024x18 video RAM as seen by the scanout engine.
// Handshake: none. The scanout engine (master) presents read_ad every clock
// and the RAM (slave) returns read_data for that address one clock later;
// there is no valid/ready and no back-pressure. read_wre is held at 0.
interface video_ram_scanout_if;
  import video_scanout_pkg::*;

  logic [RAM_AW-1:0] read_ad;
  logic              read_wre;
  logic [RAM_DW-1:0] read_data;

  modport master (output read_ad, output read_wre, input read_data);
  modport slave  (input read_ad, input read_wre, output read_data);

endinterface

// File: rtl/video_ram_scanout_timing_gen.sv
// Raster timing for the scanout engine: h/v counters plus active, sync,
// frame-origin and frame-wrap decode. Line and frame order is
// active, front porch, sync, back porch. en=0 parks the raster at (0,0).
module video_timing_gen #(
  parameter int H_ACTIVE = 64,
  parameter int H_FP     = 4,
  parameter int H_SYNC   = 8,
  parameter int H_BP     = 4,
  parameter int V_ACTIVE = 32,
  parameter int V_FP     = 2,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 2,
  parameter int HW       = $clog2(H_ACTIVE + H_FP + H_SYNC + H_BP),
  parameter int VW       = $clog2(V_ACTIVE + V_FP + V_SYNC + V_BP)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          en,
  output logic [HW-1:0] h,
  output logic [VW-1:0] v,
  output logic          active,
  output logic          hsync,
  output logic          vsync,
  output logic          origin,
  output logic          frame_wrap
);

  localparam logic [HW-1:0] H_LAST = HW'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [HW-1:0] H_ACT  = HW'(H_ACTIVE);
  localparam logic [HW-1:0] HS_BEG = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_END = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0] V_LAST = VW'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam logic [VW-1:0] V_ACT  = VW'(V_ACTIVE);
  localparam logic [VW-1:0] VS_BEG = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_END = VW'(V_ACTIVE + V_FP + V_SYNC);

  // Raster counters: h wraps into v, v wraps to 0; held at origin when idle.
  always_ff @(posedge clk) begin
    if (!reset || !en) begin
      h <= '0;
      v <= '0;
    end else if (h == H_LAST) begin
      h <= '0;
      if (v == V_LAST) v <= '0;
      else             v <= v + VW'(1);
    end else begin
      h <= h + HW'(1);
    end
  end

  assign active     = (h < H_ACT) && (v < V_ACT);
  assign hsync      = (h >= HS_BEG) && (h < HS_END);
  assign vsync      = (v >= VS_BEG) && (v < VS_END);
  assign origin     = (h == '0) && (v == '0);
  assign frame_wrap = (h == H_LAST) && (v == V_LAST);

endmodule

// File: rtl/video_ram_scanout.sv
// Scanout engine for the 1024x18 dual-port video RAM (read port B).
// S0 raster counters -> S1 read_ad registered -> S2 read_data from RAM ->
// S3 rgb/de/syncs/frame_start registered. Side information follows the
// RAM access through matching stages so everything leaves aligned.
// Build option: VIDEO_SCANOUT_DOUBLE_EN (2x pixel and line doubling).
module video_ram_scanout
  import video_scanout_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = 4,
  parameter int H_SYNC   = 8,
  parameter int H_BP     = 4,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = 2,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 en,
  input  logic [4:0]           scroll_y,
  video_ram_scanout_if.master  ram,
  output rgb333_t              rgb,
  output logic                 de,
  output logic                 hsync_n,
  output logic                 vsync_n,
  output logic                 frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);
  localparam int V_ROWS  = V_ACTIVE >> REP_SHIFT;        // stored rows shown
  localparam int WPR     = H_ACTIVE >> (REP_SHIFT + 1);  // words per stored row

  logic [HW-1:0]     h;
  logic [VW-1:0]     v;
  logic              active, hsync, vsync, origin, frame_wrap;
  logic [4:0]        scroll_lat;
  logic [RAM_AW-1:0] row_sum, row_idx, col_idx, addr_next;
  pipe_tag_t         tag0, tag1, tag2;

  video_timing_gen #(
    .H_ACTIVE (H_ACTIVE), .H_FP (H_FP), .H_SYNC (H_SYNC), .H_BP (H_BP),
    .V_ACTIVE (V_ACTIVE), .V_FP (V_FP), .V_SYNC (V_SYNC), .V_BP (V_BP),
    .HW       (HW),       .VW   (VW)
  ) u_timing (
    .clk        (clk),
    .reset      (reset),
    .en         (en),
    .h          (h),
    .v          (v),
    .active     (active),
    .hsync      (hsync),
    .vsync      (vsync),
    .origin     (origin),
    .frame_wrap (frame_wrap)
  );

  // Scroll is only picked up at a frame boundary or while parked, so a
  // frame never tears.
  always_ff @(posedge clk) begin
    if (!reset)          scroll_lat <= '0;
    else if (!en)        scroll_lat <= scroll_y;
    else if (frame_wrap) scroll_lat <= scroll_y;
  end

  // Stored row wraps inside the buffer; column is the word within the row.
  assign row_sum   = RAM_AW'(v >> REP_SHIFT) + RAM_AW'(scroll_lat);
  assign row_idx   = row_sum % RAM_AW'(V_ROWS);
  assign col_idx   = RAM_AW'(h >> (REP_SHIFT + 1));
  assign addr_next = (row_idx * RAM_AW'(WPR)) + col_idx;

  assign tag0.valid = active;
  assign tag0.hsync = hsync;
  assign tag0.vsync = vsync;
  assign tag0.first = origin;
  assign tag0.sel   = h[REP_SHIFT];

  assign ram.read_wre = 1'b0;

  // S1: address register; it only moves on visible pixels so the bus stays
  // quiet during blanking.
  always_ff @(posedge clk) begin
    if (!reset || !en) begin
      ram.read_ad <= '0;
      tag1        <= '0;
    end else begin
      tag1 <= tag0;
      if (tag0.valid) ram.read_ad <= addr_next;
    end
  end

  // S2: side information waits while the RAM produces read_data.
  always_ff @(posedge clk) begin
    if (!reset || !en) tag2 <= '0;
    else               tag2 <= tag1;
  end

  // S3: pixel select, blanking and active-low syncs onto the pins.
  always_ff @(posedge clk) begin
    if (!reset || !en) begin
      rgb         <= '0;
      de          <= 1'b0;
      hsync_n     <= 1'b1;
      vsync_n     <= 1'b1;
      frame_start <= 1'b0;
    end else begin
      rgb         <= tag2.valid ? pixel_slice(ram.read_data, tag2.sel) : '0;
      de          <= tag2.valid;
      hsync_n     <= ~tag2.hsync;
      vsync_n     <= ~tag2.vsync;
      frame_start <= tag2.first;
    end
  end

endmodule

// File: tb/tb_video_ram_scanout.sv
// Bench for video_ram_scanout: synchronous RAM model on port B, raster
// reference model that tracks the linear pixel position of the frame and
// computes each pixel from the frame buffer with plain div/mod arithmetic.
module tb_video_ram_scanout;
  import video_scanout_pkg::*;

`ifdef VIDEO_SCANOUT_DOUBLE_EN
  localparam int REP = 2;
  localparam int HA  = 128;
  localparam int VA  = 64;
`else
  localparam int REP = 1;
  localparam int HA  = 64;
  localparam int VA  = 32;
`endif
  localparam int HT   = HA + 4 + 8 + 4;
  localparam int VT   = VA + 2 + 2 + 2;
  localparam int FT   = HT * VT;
  localparam int ROWS = 32;
  localparam int WPR  = 32;
  // {frame_start, vsync_n, hsync_n, de, rgb}
  localparam logic [12:0] BLANK = {1'b0, 1'b1, 1'b1, 1'b0, 9'd0};

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic       en;
  logic [4:0] scroll_y;
  logic [8:0] rgb;
  logic       de, hsync_n, vsync_n, frame_start;

  video_ram_scanout_if ram_bus ();

  video_ram_scanout dut (
    .clk         (clk),
    .reset       (reset),
    .en          (en),
    .scroll_y    (scroll_y),
    .ram         (ram_bus),
    .rgb         (rgb),
    .de          (de),
    .hsync_n     (hsync_n),
    .vsync_n     (vsync_n),
    .frame_start (frame_start)
  );

  // RAM port B: registered read, data one clock after the address.
  logic [17:0] mem [1024];
  always @(posedge clk) ram_bus.read_data <= mem[ram_bus.read_ad];

  // ---------------- scoreboard / model ----------------
  int          n_checks = 0;
  int          n_fail   = 0;
  int          pos;        // linear raster position of the next S0 cycle
  logic [4:0]  scroll_f;   // scroll in force for the current frame
  logic [12:0] exp_q[$];
  logic [12:0] exp_out;
  logic [9:0]  exp_ad;

  task automatic chk(input string tag, input logic [12:0] obs, input logic [12:0] expv);
    n_checks++;
    assert (obs === expv)
    else begin
      n_fail++;
      $error("FAIL %s at %0t: observed=%0h expected=%0h", tag, $time, obs, expv);
    end
  endtask

  task automatic model_step();
    int h, v, sh, sv, row, addr;
    logic [17:0] w;
    logic [8:0]  pix;
    logic        act;
    if (!reset || !en) begin
      pos      = 0;
      scroll_f = !reset ? 5'd0 : scroll_y;
      exp_q    = {BLANK, BLANK};
      exp_out  = BLANK;
      exp_ad   = '0;
    end else begin
      h    = pos % HT;
      v    = pos / HT;
      act  = (h < HA) && (v < VA);
      sh   = h / REP;
      sv   = v / REP;
      row  = (sv + int'(scroll_f)) % ROWS;
      addr = row * WPR + sh / 2;
      pix  = '0;
      if (act) begin
        w   = mem[addr];
        pix = (sh % 2 == 1) ? w[17:9] : w[8:0];
        exp_ad = 10'(addr);
      end
      exp_q.push_back({act && h == 0 && v == 0,
                       !(v >= VA + 2 && v < VA + 4),
                       !(h >= HA + 4 && h < HA + 12),
                       act, pix});
      exp_out = exp_q.pop_front();
      pos++;
      if (pos == FT) begin
        pos      = 0;
        scroll_f = scroll_y;
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    chk("rgb",         13'(rgb),              13'(exp_out[8:0]));
    chk("de",          13'(de),               13'(exp_out[9]));
    chk("hsync_n",     13'(hsync_n),          13'(exp_out[10]));
    chk("vsync_n",     13'(vsync_n),          13'(exp_out[11]));
    chk("frame_start", 13'(frame_start),      13'(exp_out[12]));
    chk("read_ad",     13'(ram_bus.read_ad),  13'(exp_ad));
    chk("read_wre",    13'(ram_bus.read_wre), 13'(1'b0));
  endtask

  task automatic run_ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic run_to(input int target);
    int budget;
    budget = 2 * FT;
    while (pos != target && budget > 0) begin
      tick();
      budget--;
    end
    n_checks++;
    assert (pos === target)
    else begin
      n_fail++;
      $error("FAIL run_to: observed_pos=%0d expected_pos=%0d", pos, target);
    end
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    logic [4:0] x;
    logic [9:0] nv;
    reset    = 1'b0;
    en       = 1'b1;
    scroll_y = 5'd0;
    for (int i = 0; i < 1024; i++) begin
      nv     = 10'(i);
      mem[i] = {nv[8:0], ~nv[8:0]};
    end
    pos      = 0;
    scroll_f = '0;
    exp_q    = {BLANK, BLANK};
    exp_out  = BLANK;
    exp_ad   = '0;

    // Reset held low three clocks: every output at its reset value.
    run_ticks(3);
    chk("reset_de",    13'(de),      13'(1'b0));
    chk("reset_hsync", 13'(hsync_n), 13'(1'b1));

    // Release: first visible pixel and frame_start exactly 3 clocks later.
    reset = 1'b1;
    run_ticks(2);
    chk("early_fs", 13'(frame_start), 13'(1'b0));
    tick();
    chk("first_fs",  13'(frame_start), 13'(1'b1));
    chk("first_de",  13'(de),          13'(1'b1));
    chk("first_rgb", 13'(rgb),         13'(9'h1FF));

    // Finish frame 1 with scroll 0, then request scroll 31 mid frame 2.
    run_ticks(FT - 3 + 100);
    scroll_y = 5'd31;
    run_to(1);
    chk("scroll31_line0", 13'(ram_bus.read_ad), 13'(10'd992));
    run_to(REP * HT + 1);
    chk("scroll31_line1", 13'(ram_bus.read_ad), 13'(10'd0));

    // Mid-frame scroll change must wait for the next frame.
    x        = 5'($urandom_range(1, 30));
    scroll_y = x;
    run_to(1);
    chk("scroll_next_frame", 13'(ram_bus.read_ad), 13'({x, 5'd0}));

    // Drop en at h=20, v=5: blank on the next clock.
    run_to(5 * HT + 20);
    en = 1'b0;
    tick();
    chk("off_de",    13'(de),          13'(1'b0));
    chk("off_rgb",   13'(rgb),         13'(9'd0));
    chk("off_hsync", 13'(hsync_n),     13'(1'b1));
    chk("off_vsync", 13'(vsync_n),     13'(1'b1));
    chk("off_ad",    13'(ram_bus.read_ad), 13'(10'd0));
    for (int i = 0; i < 1024; i++) mem[i] = 18'($urandom);
    scroll_y = 5'($urandom_range(0, 31));
    run_ticks(4);

    // Re-enable: raster restarts at origin, frame_start 3 clocks later.
    en = 1'b1;
    run_ticks(2);
    chk("reen_early_fs", 13'(frame_start), 13'(1'b0));
    tick();
    chk("reen_fs", 13'(frame_start), 13'(1'b1));
    chk("reen_de", 13'(de),          13'(1'b1));

    // Randomized enable drops and scroll changes.
    for (int k = 0; k < 6; k++) begin
      run_ticks($urandom_range(50, FT / 4));
      if ($urandom_range(0, 1) == 1) begin
        en = 1'b0;
        scroll_y = 5'($urandom_range(0, 31));
        tick();
        for (int i = 0; i < 64; i++) mem[$urandom_range(0, 1023)] = 18'($urandom);
        run_ticks($urandom_range(1, 4));
        en = 1'b1;
      end else begin
        scroll_y = 5'($urandom_range(0, 31));
      end
    end
    run_ticks(FT / 2);

    // ---------------- final report ----------------
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
